// File: rtl/hdmi_timing_scheduler.sv
// Raster timing generator and pixel-fetch scheduler for the TMDS pixel domain.
// Stage 0 runs the h/v counters and issues fetches, stage 1 carries the raster
// flags while the source returns the pixel, stage 2 registers DE/sync/colour.
module hdmi_timing_scheduler #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CW        = 12
) (
    input  logic          i_pixel_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    output logic          o_px_req,
    output logic [CW-1:0] o_px_x,
    output logic [CW-1:0] o_px_y,
    input  logic          i_px_valid,
    input  logic [7:0]    i_px_r,
    input  logic [7:0]    i_px_g,
    input  logic [7:0]    i_px_b,
    output logic          o_hdmi_de,
    output logic          o_hdmi_hsync,
    output logic          o_hdmi_vsync,
    output logic [7:0]    o_pixel_r,
    output logic [7:0]    o_pixel_g,
    output logic [7:0]    o_pixel_b,
    output logic          o_frame_start,
    output logic          o_busy,
    output logic          o_underflow,
    input  logic          i_underflow_clr
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] h, v;
    logic          run0, at_last;
    logic          act0, hs0, vs0, first0;
    logic [2:1]    vld_pipe;   // running-cycle tokens held by stages 1 and 2
    logic          s1_act, s1_hs, s1_vs, s1_first;

    assign run0    = (state != ST_OFF);
    assign at_last = (h == H_LAST) && (v == V_LAST);

    // Stage-0 raster decode; an idle scheduler looks like blanking.
    assign act0   = run0 && (h < H_ACT_C) && (v < V_ACT_C);
    assign hs0    = run0 && (h >= HS_BEG) && (h <= HS_END);
    assign vs0    = run0 && (v >= VS_BEG) && (v <= VS_END);
    assign first0 = run0 && (h == '0) && (v == '0);

    assign o_px_req = act0;
    assign o_px_x   = act0 ? h : '0;
    assign o_px_y   = act0 ? v : '0;
    assign o_busy   = run0 || vld_pipe[1] || vld_pipe[2];

    // Run/stop control: stopping only ends on a frame boundary, and can be
    // cancelled mid-frame without disturbing the raster.
    always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_OFF;
        end else begin
            case (state)
                ST_OFF:  if (i_en) state <= ST_RUN;
                ST_RUN:  if (!i_en) state <= ST_STOP;
                ST_STOP: if (i_en) state <= ST_RUN;
                         else if (at_last) state <= ST_OFF;
                default: state <= ST_OFF;
            endcase
        end
    end

    // Raster counters; parked at (0,0) while off so a start begins a frame.
    always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h <= '0;
            v <= '0;
        end else if (!run0) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Stage 1: carry raster flags while the source returns the pixel.
    always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_act   <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_first <= 1'b0;
            vld_pipe <= '0;
        end else begin
            s1_act   <= act0;
            s1_hs    <= hs0;
            s1_vs    <= vs0;
            s1_first <= first0;
            vld_pipe <= {vld_pipe[1], run0};
        end
    end

    // Stage 2: encoder-facing registers; a missing return is sent as black.
    always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hdmi_de     <= 1'b0;
            o_hdmi_hsync  <= ~HSYNC_POL;
            o_hdmi_vsync  <= ~VSYNC_POL;
            o_pixel_r     <= 8'h00;
            o_pixel_g     <= 8'h00;
            o_pixel_b     <= 8'h00;
            o_frame_start <= 1'b0;
        end else begin
            o_hdmi_de     <= s1_act;
            o_hdmi_hsync  <= s1_hs ? HSYNC_POL : ~HSYNC_POL;
            o_hdmi_vsync  <= s1_vs ? VSYNC_POL : ~VSYNC_POL;
            o_pixel_r     <= (s1_act && i_px_valid) ? i_px_r : 8'h00;
            o_pixel_g     <= (s1_act && i_px_valid) ? i_px_g : 8'h00;
            o_pixel_b     <= (s1_act && i_px_valid) ? i_px_b : 8'h00;
            o_frame_start <= s1_first;
        end
    end

    // Sticky underflow: a new miss outranks a same-cycle clear.
    always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_underflow <= 1'b0;
        end else if (s1_act && !i_px_valid) begin
            o_underflow <= 1'b1;
        end else if (i_underflow_clr) begin
            o_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hdmi_timing_scheduler.sv
// Randomised scoreboard bench for hdmi_timing_scheduler on a tiny 8x6 raster.
// The reference model tracks a linear position within the frame plus a
// running flag; expected responses are queued per cycle and a monitor on the
// falling edge pops and compares them.
module tb_hdmi_timing_scheduler;
    localparam int HA = 4, HFP = 1, HSY = 2, HBP = 1;
    localparam int VA = 3, VFP = 1, VSY = 1, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_en = 1'b0;
    logic          px_req;
    logic [CW-1:0] px_x, px_y;
    logic          px_valid = 1'b0;
    logic [7:0]    px_r = 8'h00, px_g = 8'h00, px_b = 8'h00;
    logic          de, hsync, vsync;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic          frame_start, busy, underflow;
    logic          und_clr = 1'b0;

    hdmi_timing_scheduler #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(CW)
    ) dut (
        .i_pixel_clk(clk), .i_rst_n(rst_n), .i_en(i_en),
        .o_px_req(px_req), .o_px_x(px_x), .o_px_y(px_y),
        .i_px_valid(px_valid), .i_px_r(px_r), .i_px_g(px_g), .i_px_b(px_b),
        .o_hdmi_de(de), .o_hdmi_hsync(hsync), .o_hdmi_vsync(vsync),
        .o_pixel_r(pix_r), .o_pixel_g(pix_g), .o_pixel_b(pix_b),
        .o_frame_start(frame_start), .o_busy(busy),
        .o_underflow(underflow), .i_underflow_clr(und_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit req;
        int x;
        int y;
        bit busy;
    } req_exp_t;

    typedef struct {
        int       due;
        bit       de, hs, vs, fs, und;
        bit [7:0] r, g, b;
    } out_exp_t;

    req_exp_t req_q[$];
    out_exp_t out_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // reference model state
    bit m_run = 1'b0;
    int m_pos = 0;
    bit m_und = 1'b0;
    bit en_p1 = 1'b0, en_p2 = 1'b0;
    bit h_act = 1'b0, h_hs = 1'b0, h_vs = 1'b0, h_fs = 1'b0;
    int h_x = 0, h_y = 0;
    bit h_run1 = 1'b0, h_run2 = 1'b0;
    bit rand_drops = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    endtask

    // One clock of stimulus. clr_mode: 0 none, 1 pulse, 2 random,
    // 3 pulse only in the cycle a forced drop is presented.
    task automatic step(input bit en, input bit force_drop, input int clr_mode);
        int x, y;
        bit act, hs, vs, fs, vok, clr, drop;
        bit [7:0] r, g, b;
        req_exp_t rq;
        out_exp_t oq;
        @(posedge clk);
        #1;
        cyc++;
        // A stop takes effect only at the last position of a frame with the
        // run request low both there and in the preceding cycle.
        if (!m_run) begin
            if (en_p1) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == FRAME - 1 && !en_p1 && !en_p2) begin
            m_run = 1'b0;
            m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
        end
        x   = m_pos % HT;
        y   = m_pos / HT;
        act = m_run && x < HA && y < VA;
        hs  = m_run && x >= HA + HFP && x < HA + HFP + HSY;
        vs  = m_run && y >= VA + VFP && y < VA + VFP + VSY;
        fs  = m_run && m_pos == 0;

        // source response to last cycle's request
        drop = 1'b0;
        if (h_act) begin
            if (force_drop && h_x == 2 && h_y == 1) drop = 1'b1;
            if (rand_drops && $urandom_range(0, 9) == 0) drop = 1'b1;
            vok = !drop;
            r = 8'(h_x);
            g = 8'(h_y);
            b = 8'(h_x ^ h_y);
        end else begin
            vok = ($urandom_range(0, 5) == 0);
            r = 8'($urandom);
            g = 8'($urandom);
            b = 8'($urandom);
        end
        case (clr_mode)
            1:       clr = 1'b1;
            2:       clr = ($urandom_range(0, 11) == 0);
            3:       clr = drop;
            default: clr = 1'b0;
        endcase
        i_en = en;
        px_valid = vok;
        px_r = r;
        px_g = g;
        px_b = b;
        und_clr = clr;

        rq.due  = cyc;
        rq.req  = act;
        rq.x    = act ? x : 0;
        rq.y    = act ? y : 0;
        rq.busy = m_run || h_run1 || h_run2;
        req_q.push_back(rq);

        m_und  = (h_act && !vok) ? 1'b1 : (clr ? 1'b0 : m_und);
        oq.due = cyc + 1;
        oq.de  = h_act;
        oq.hs  = !h_hs;
        oq.vs  = !h_vs;
        oq.fs  = h_fs;
        oq.und = m_und;
        oq.r   = (h_act && vok) ? r : 8'h00;
        oq.g   = (h_act && vok) ? g : 8'h00;
        oq.b   = (h_act && vok) ? b : 8'h00;
        out_q.push_back(oq);

        h_act = act; h_hs = hs; h_vs = vs; h_fs = fs;
        h_x = x; h_y = y;
        h_run2 = h_run1; h_run1 = m_run;
        en_p2 = en_p1; en_p1 = en;
    endtask

    task automatic model_reset(input bit en_now);
        m_run = 1'b0; m_pos = 0; m_und = 1'b0;
        en_p1 = en_now; en_p2 = en_now;
        h_act = 1'b0; h_hs = 1'b0; h_vs = 1'b0; h_fs = 1'b0;
        h_x = 0; h_y = 0; h_run1 = 1'b0; h_run2 = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_px_req", int'(px_req), 0);
        chk("rst_de", int'(de), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_pixel", int'({pix_r, pix_g, pix_b}), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_underflow", int'(underflow), 0);
        chk("rst_busy", int'(busy), 0);
    endtask

    // monitor: compare whatever expectation is due this cycle
    always @(negedge clk) begin : mon
        req_exp_t rq;
        out_exp_t oq;
        if (mon_en) begin
            if (req_q.size() > 0 && req_q[0].due == cyc) begin
                rq = req_q.pop_front();
                chk("px_req", int'(px_req), int'(rq.req));
                chk("px_x", int'(px_x), rq.x);
                chk("px_y", int'(px_y), rq.y);
                chk("busy", int'(busy), int'(rq.busy));
            end
            if (out_q.size() > 0 && out_q[0].due == cyc) begin
                oq = out_q.pop_front();
                chk("de", int'(de), int'(oq.de));
                chk("hsync", int'(hsync), int'(oq.hs));
                chk("vsync", int'(vsync), int'(oq.vs));
                chk("pixel_r", int'(pix_r), int'(oq.r));
                chk("pixel_g", int'(pix_g), int'(oq.g));
                chk("pixel_b", int'(pix_b), int'(oq.b));
                chk("frame_start", int'(frame_start), int'(oq.fs));
                chk("underflow", int'(underflow), int'(oq.und));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        bit en_r;
        #12;
        chk_reset_outputs();
        @(negedge clk);
        model_reset(1'b0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // idle, then clean start with every fetch returned
        repeat (4) step(1'b0, 1'b0, 0);
        repeat (2 * FRAME) step(1'b1, 1'b0, 0);

        // forced miss at (2,1): sticky until cleared
        repeat (FRAME + 20) step(1'b1, 1'b1, 0);
        step(1'b1, 1'b0, 1);
        repeat (10) step(1'b1, 1'b0, 0);
        // miss and clear land together: flag must stay set
        repeat (FRAME) step(1'b1, 1'b1, 3);
        step(1'b1, 1'b0, 1);
        repeat (5) step(1'b1, 1'b0, 0);

        // drop the run request at (1,1): frame completes, then off
        for (int i = 0; i < 2 * FRAME && !(m_run && m_pos == HT + 0); i++)
            step(1'b1, 1'b0, 0);
        repeat (FRAME + 20) step(1'b0, 1'b0, 0);

        // restart, stop mid-frame, re-request while still stopping
        repeat (30) step(1'b1, 1'b0, 0);
        repeat (10) step(1'b0, 1'b0, 0);
        repeat (FRAME + 30) step(1'b1, 1'b0, 0);

        // randomised run/stop with random misses and clears
        rand_drops = 1'b1;
        en_r = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) en_r = !en_r;
            step(en_r, 1'b0, 2);
        end

        // reset mid active line with the run request held
        for (int i = 0; i < 4 * FRAME && !(m_run && m_pos == HT + 1); i++)
            step(1'b1, 1'b0, 2);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        req_q.delete();
        out_q.delete();
        repeat (2) @(negedge clk);
        model_reset(1'b1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2 * FRAME) step(1'b1, 1'b0, 2);
        repeat (FRAME + 10) step(1'b0, 1'b0, 0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
